// File: rtl/fp_minmax_pipe.sv
// Pipelined IEEE-754 FMIN/FMAX with RISC-V NaN and signed-zero semantics, tag passthrough.
// Optional define FP_MINMAX_FLAGS_EN adds the invalid-operation flag (sNaN input) to each result.
module fp_minmax_pipe #(
   parameter int EXP_W       = 8,
   parameter int MAN_W       = 23,
   parameter int PIPE_STAGES = 2,
   parameter int TAG_W       = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [EXP_W+MAN_W:0]     in_a,
   input  logic [EXP_W+MAN_W:0]     in_b,
   input  logic                     in_op,
   input  logic [TAG_W-1:0]         in_tag,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [EXP_W+MAN_W:0]     out_z,
   output logic [TAG_W-1:0]         out_tag,
   output logic                     out_nv
);

   localparam int W    = 1 + EXP_W + MAN_W;
   localparam int LAST = PIPE_STAGES - 1;
   localparam logic [W-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   // Handshake: a word moves on a port in any cycle where its valid and ready are both high.
   // The whole pipe advances together, so in_ready is simply "the output slot is free or
   // being drained"; holding the output also freezes every stage behind it.
   logic advance;
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   logic                   a_sign, b_sign;
   logic [EXP_W+MAN_W-1:0] a_mag, b_mag;
   logic                   a_nan, b_nan;
   logic                   a_lt_b, b_lt_a;
   logic [W-1:0]           sel_z;

   assign a_sign = in_a[W-1];
   assign b_sign = in_b[W-1];
   assign a_mag  = in_a[W-2:0];
   assign b_mag  = in_b[W-2:0];
   assign a_nan  = (&in_a[W-2:MAN_W]) && (|in_a[MAN_W-1:0]);
   assign b_nan  = (&in_b[W-2:MAN_W]) && (|in_b[MAN_W-1:0]);

   // Raw {exp,man} order matches numeric order within one sign; negatives invert it.
   always_comb begin
      a_lt_b = 1'b0;
      b_lt_a = 1'b0;
      if (a_sign != b_sign) begin
         a_lt_b = a_sign;
         b_lt_a = b_sign;
      end else if (!a_sign) begin
         a_lt_b = a_mag < b_mag;
         b_lt_a = b_mag < a_mag;
      end else begin
         a_lt_b = a_mag > b_mag;
         b_lt_a = b_mag > a_mag;
      end
   end

   always_comb begin
      sel_z = in_a;
      if (a_nan && b_nan) begin
         sel_z = CANON_NAN;
      end else if (a_nan) begin
         sel_z = in_b;
      end else if (b_nan) begin
         sel_z = in_a;
      end else if (in_op) begin
         sel_z = a_lt_b ? in_b : in_a;
      end else begin
         sel_z = b_lt_a ? in_b : in_a;
      end
   end

   logic             stg_valid [PIPE_STAGES];
   logic [W-1:0]     stg_z     [PIPE_STAGES];
   logic [TAG_W-1:0] stg_tag   [PIPE_STAGES];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < PIPE_STAGES; i++) begin
            stg_valid[i] <= 1'b0;
            stg_z[i]     <= '0;
            stg_tag[i]   <= '0;
         end
      end else if (advance) begin
         stg_valid[0] <= in_valid;
         stg_z[0]     <= sel_z;
         stg_tag[0]   <= in_tag;
         for (int i = 1; i < PIPE_STAGES; i++) begin
            stg_valid[i] <= stg_valid[i-1];
            stg_z[i]     <= stg_z[i-1];
            stg_tag[i]   <= stg_tag[i-1];
         end
      end
   end

   assign out_valid = stg_valid[LAST];
   assign out_z     = stg_z[LAST];
   assign out_tag   = stg_tag[LAST];

`ifdef FP_MINMAX_FLAGS_EN
   // Signalling NaN has the quiet bit (mantissa MSB) clear.
   logic sel_nv;
   logic stg_nv [PIPE_STAGES];

   assign sel_nv = (a_nan && !in_a[MAN_W-1]) || (b_nan && !in_b[MAN_W-1]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < PIPE_STAGES; i++) begin
            stg_nv[i] <= 1'b0;
         end
      end else if (advance) begin
         stg_nv[0] <= sel_nv;
         for (int i = 1; i < PIPE_STAGES; i++) begin
            stg_nv[i] <= stg_nv[i-1];
         end
      end
   end

   assign out_nv = stg_nv[LAST];
`else
   assign out_nv = 1'b0;
`endif

endmodule

// File: tb/tb_fp_minmax_pipe.sv
// Self-checking bench for fp_minmax_pipe (fp32, 2 stages): scoreboard queue fed by the driver,
// drained by an independent monitor; expectations come from a value-level min/max model.
module tb_fp_minmax_pipe;

   localparam int W  = 32;
   localparam int TW = 5;
   localparam int EW = 1 + TW + W;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_a = '0;
   logic [W-1:0]  in_b = '0;
   logic          in_op = 1'b0;
   logic [TW-1:0] in_tag = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  out_z;
   logic [TW-1:0] out_tag;
   logic          out_nv;

   fp_minmax_pipe #(.EXP_W(8), .MAN_W(23), .PIPE_STAGES(2), .TAG_W(TW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_z(out_z), .out_tag(out_tag), .out_nv(out_nv)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] held;
   logic          have_held = 1'b0;
   logic          rand_done = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic is_nan(input logic [W-1:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
   endfunction

   function automatic logic is_snan(input logic [W-1:0] x);
      return is_nan(x) && !x[22];
   endfunction

   function automatic int key(input logic [W-1:0] x);
      int m;
      m = int'({1'b0, x[30:0]});
      return x[31] ? -m : m;
   endfunction

   function automatic logic [EW-1:0] model(input logic op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [TW-1:0] tag);
      logic [W-1:0] z;
      logic a_less, b_less, nv;
      if (is_nan(a) && is_nan(b)) z = 32'h7FC00000;
      else if (is_nan(a)) z = b;
      else if (is_nan(b)) z = a;
      else begin
         a_less = (key(a) < key(b)) || (key(a) == key(b) && a[31] && !b[31]);
         b_less = (key(b) < key(a)) || (key(a) == key(b) && b[31] && !a[31]);
         if (op) z = a_less ? b : a;
         else    z = b_less ? b : a;
      end
`ifdef FP_MINMAX_FLAGS_EN
      nv = is_snan(a) || is_snan(b);
`else
      nv = 1'b0;
`endif
      return {nv, tag, z};
   endfunction

   // ---------------- driver ----------------
   task automatic send(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TW-1:0] tag, input logic [EW-1:0] expv);
      int n;
      @(negedge clk);
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
      #1;
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk); #1; n++;
      end
      if (!in_ready) begin
         checks++; failures++;
         $display("FAIL send_timeout actual=in_ready=0 required=1 at %0t", $time);
      end else begin
         exp_q.push_back(expv);
      end
   endtask

   task automatic send_m(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [TW-1:0] tag);
      send(op, a, b, tag, model(op, a, b, tag));
   endtask

   // Directed vector with a hand-written expected result; nvf is the flag when flags are built in.
   task automatic send_d(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [TW-1:0] tag, input logic [W-1:0] z, input logic nvf);
      logic nv;
`ifdef FP_MINMAX_FLAGS_EN
      nv = nvf;
`else
      nv = 1'b0 & nvf;
`endif
      send(op, a, b, tag, {nv, tag, z});
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      idle();
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk); n++;
      end
      check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
   endtask

   function automatic logic [W-1:0] rand_operand();
      logic s;
      logic [31:0] r;
      s = 1'($urandom_range(0, 1));
      r = $urandom;
      case ($urandom_range(0, 7))
         0: return r;
         1: return {s, 31'd0};
         2: return {s, 8'hFF, 23'd0};
         3: return {s, 8'hFF, 1'b1, r[21:0]};
         4: return {s, 8'hFF, 1'b0, r[21:1], 1'b1};
         5: return {s, 8'h00, r[22:0]};
         6: return {s, 8'h7F, r[22:0]};
         default: return {s, 8'h80, r[22:0]};
      endcase
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      #2;
      if (rst) begin
         have_held = 1'b0;
      end else begin
         check("in_ready_vs_advance", {63'd0, in_ready}, {63'd0, (!out_valid || out_ready)});
         if (have_held) begin
            check("stall_valid_held", {63'd0, out_valid}, 64'd1);
            check("stall_payload_held", 64'({out_nv, out_tag, out_z}), 64'(held));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_output actual=%h required=none at %0t",
                        {out_nv, out_tag, out_z}, $time);
            end else begin
               check("result", 64'({out_nv, out_tag, out_z}), 64'(exp_q.pop_front()));
            end
         end
         have_held = out_valid && !out_ready;
         held = {out_nv, out_tag, out_z};
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   // ---------------- main sequence ----------------
   initial begin
      repeat (3) @(negedge clk);
      #1;
      check("reset_out_valid", {63'd0, out_valid}, 64'd0);
      check("reset_payload", 64'({out_nv, out_tag, out_z}), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk); #1;
      check("ready_after_reset", {63'd0, in_ready}, 64'd1);

      // basic ordering, signed zero, NaN cases
      send_d(1'b1, 32'h3F800000, 32'h40000000, 5'd3,  32'h40000000, 1'b0);
      send_d(1'b0, 32'h3F800000, 32'h40000000, 5'd4,  32'h3F800000, 1'b0);
      send_d(1'b0, 32'h00000000, 32'h80000000, 5'd5,  32'h80000000, 1'b0);
      send_d(1'b1, 32'h00000000, 32'h80000000, 5'd6,  32'h00000000, 1'b0);
      send_d(1'b0, 32'hBF800000, 32'hC0000000, 5'd7,  32'hC0000000, 1'b0);
      send_d(1'b0, 32'h7FC00000, 32'hC0400000, 5'd8,  32'hC0400000, 1'b0);
      send_d(1'b1, 32'h7F800001, 32'h3F800000, 5'd9,  32'h3F800000, 1'b1);
      send_d(1'b1, 32'h7F800001, 32'hFFC00000, 5'd10, 32'h7FC00000, 1'b1);
      send_d(1'b0, 32'hFF800000, 32'h7FC00000, 5'd11, 32'hFF800000, 1'b0);
      send_d(1'b1, 32'h7F7FFFFF, 32'h7F800000, 5'd12, 32'h7F800000, 1'b0);
      send_d(1'b0, 32'h80000000, 32'h80000000, 5'd13, 32'h80000000, 1'b0);
      send_d(1'b1, 32'h00000001, 32'h80000001, 5'd14, 32'h00000001, 1'b0);
      drain();

      // back-to-back stream with a 5-cycle output stall
      fork
         begin
            for (int i = 0; i < 8; i++)
               send_m(1'($urandom_range(0, 1)), rand_operand(), rand_operand(), TW'(16 + i));
            idle();
         end
         begin
            repeat (3) @(negedge clk);
            out_ready = 1'b0;
            @(negedge clk); #1;
            check("stall_in_ready_low", {63'd0, in_ready}, 64'd0);
            repeat (4) @(negedge clk);
            out_ready = 1'b1;
         end
      join
      drain();

      // reset with two results in flight
      out_ready = 1'b0;
      send_m(1'b1, 32'h40400000, 32'h40800000, 5'd1);
      send_m(1'b0, 32'h40400000, 32'h40800000, 5'd2);
      idle();
      @(negedge clk); #3;
      rst = 1'b1;
      #1;
      check("async_reset_out_valid", {63'd0, out_valid}, 64'd0);
      check("async_reset_payload", 64'({out_nv, out_tag, out_z}), 64'd0);
      exp_q.delete();
      @(negedge clk); #3;
      rst = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(negedge clk);
      send_d(1'b1, 32'hC0A00000, 32'h40A00000, 5'd21, 32'h40A00000, 1'b0);
      drain();

      // randomized traffic with random backpressure
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               logic [W-1:0] a, b;
               a = rand_operand();
               case ($urandom_range(0, 5))
                  0: b = a;
                  1: b = a ^ 32'h80000000;
                  default: b = rand_operand();
               endcase
               if ($urandom_range(0, 3) == 0) idle();
               send_m(1'($urandom_range(0, 1)), a, b, TW'($urandom));
            end
            idle();
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(negedge clk);
               out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      drain();

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
